slc3_ctrl_fsm: RTL and testbench

Parametrised instruction sequencer and decoder for the SLC-3 datapath. It is the next-generation control FSM: it drives every load-enable, gate, mux-select and memory strobe in the datapath. It generalises memory access to a configurable number of wait cycles and adds LD, ST, LEA and JSRR on top of the existing ADD/AND/NOT/BR/JMP/JSR/LDR/STR/PAUSE set. It sits between the IR/BEN logic and the datapath top level.

---
 rtl/slc3_ctrl_pkg.sv | 62 ++++++
 rtl/slc3_mem_wait_ctr.sv | 39 +++
 rtl/slc3_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 tb/tb_slc3_ctrl_fsm.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_ctrl_pkg.sv
// rtl/slc3_ctrl_pkg.sv - SLC-3 control states, opcodes and datapath select encodings
package slc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH_MAR,
        S_FETCH_MEM,
        S_FETCH_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_CHK,
        S_BR_TAKEN,
        S_JMP,
        S_JSR_LINK,
        S_JSR_JUMP,
        S_LEA,
        S_LDR_ADDR,
        S_LD_ADDR,
        S_RD_MEM,
        S_RD_WB,
        S_STR_ADDR,
        S_ST_ADDR,
        S_ST_MDR,
        S_WR_MEM,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    localparam logic [1:0] PCMUX_PC1  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH_MEM) || (s == S_RD_MEM) || (s == S_WR_MEM);
    endfunction

endpackage

// File: rtl/slc3_mem_wait_ctr.sv
// rtl/slc3_mem_wait_ctr.sv - memory access timer: fixed MEM_WAIT count, or Mem_Ready handshake under SLC3_MEM_READY_EN
module slc3_mem_wait_ctr #(
    parameter int MEM_WAIT = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic start,
    input  logic active,
`ifdef SLC3_MEM_READY_EN
    input  logic Mem_Ready,
`endif
    output logic done
);

`ifdef SLC3_MEM_READY_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, Clk, Reset, start};
    assign done      = active & Mem_Ready;
`else
    localparam int CW = $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

    logic [CW-1:0] count;

    // Holds at LAST once reached, so it never wraps between accesses
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !done) begin
            count <= count + CW'(1);
        end
    end

    assign done = active && (count == LAST);
`endif

endmodule

// File: rtl/slc3_ctrl_fsm.sv
// rtl/slc3_ctrl_fsm.sv - SLC-3 control sequencer/decoder; SLC3_MEM_READY_EN adds Mem_Ready handshake timing
module slc3_ctrl_fsm #(
    parameter int MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
`ifdef SLC3_MEM_READY_EN
    input  logic       Mem_Ready,
`endif
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Busy
);
    import slc3_ctrl_pkg::*;

    state_t state, next_state;
    logic   mem_start, mem_active, mem_done;

    // Counter is cleared in the state that precedes each memory state
    assign mem_start  = (state == S_FETCH_MAR) || (state == S_LDR_ADDR) ||
                        (state == S_LD_ADDR)   || (state == S_ST_MDR);
    assign mem_active = is_mem_state(state);

    slc3_mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (mem_start),
        .active    (mem_active),
`ifdef SLC3_MEM_READY_EN
        .Mem_Ready (Mem_Ready),
`endif
        .done      (mem_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_HALTED;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_PC1;
        DRMUX      = 1'b1;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        Busy       = (state != S_HALTED);

        case (state)
            S_HALTED: begin
                if (Run) next_state = S_FETCH_MAR;
            end
            S_FETCH_MAR: begin
                GatePC     = 1'b1;
                LD_MAR     = 1'b1;
                LD_PC      = 1'b1;
                PCMUX      = PCMUX_PC1;
                next_state = S_FETCH_MEM;
            end
            S_FETCH_MEM: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_done;
                if (mem_done) next_state = S_FETCH_IR;
            end
            S_FETCH_IR: begin
                GateMDR    = 1'b1;
                LD_IR      = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   next_state = S_ADD;
                    OP_AND:   next_state = S_AND;
                    OP_NOT:   next_state = S_NOT;
                    OP_BR:    next_state = S_BR_CHK;
                    OP_JMP:   next_state = S_JMP;
                    OP_JSR:   next_state = S_JSR_LINK;
                    OP_LEA:   next_state = S_LEA;
                    OP_LDR:   next_state = S_LDR_ADDR;
                    OP_LD:    next_state = S_LD_ADDR;
                    OP_STR:   next_state = S_STR_ADDR;
                    OP_ST:    next_state = S_ST_ADDR;
                    OP_PAUSE: next_state = S_PAUSE1;
                    default:  next_state = S_FETCH_MAR;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                SR1MUX     = 1'b1;
                SR2MUX     = IR_5;
                GateALU    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                ALUK       = (state == S_AND) ? ALUK_AND :
                             (state == S_NOT) ? ALUK_NOT : ALUK_ADD;
                next_state = S_FETCH_MAR;
            end
            S_BR_CHK: begin
                next_state = BEN ? S_BR_TAKEN : S_FETCH_MAR;
            end
            S_BR_TAKEN: begin
                ADDR2MUX   = ADDR2_OFF9;
                PCMUX      = PCMUX_ADDR;
                LD_PC      = 1'b1;
                next_state = S_FETCH_MAR;
            end
            S_JMP: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                PCMUX      = PCMUX_ADDR;
                LD_PC      = 1'b1;
                next_state = S_FETCH_MAR;
            end
            S_JSR_LINK: begin
                GatePC     = 1'b1;
                DRMUX      = 1'b0;
                LD_REG     = 1'b1;
                next_state = S_JSR_JUMP;
            end
            S_JSR_JUMP: begin
                if (IR_11) begin
                    ADDR2MUX = ADDR2_OFF11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
                PCMUX      = PCMUX_ADDR;
                LD_PC      = 1'b1;
                next_state = S_FETCH_MAR;
            end
            S_LEA: begin
                ADDR2MUX   = ADDR2_OFF9;
                GateMARMUX = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S_FETCH_MAR;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next_state = (state == S_LDR_ADDR) ? S_RD_MEM : S_ST_MDR;
            end
            S_LD_ADDR, S_ST_ADDR: begin
                ADDR2MUX   = ADDR2_OFF9;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                next_state = (state == S_LD_ADDR) ? S_RD_MEM : S_ST_MDR;
            end
            S_RD_MEM: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_done;
                if (mem_done) next_state = S_RD_WB;
            end
            S_RD_WB: begin
                GateMDR    = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
                next_state = S_FETCH_MAR;
            end
            S_ST_MDR: begin
                ALUK       = ALUK_PASSA;
                GateALU    = 1'b1;
                LD_MDR     = 1'b1;
                next_state = S_WR_MEM;
            end
            S_WR_MEM: begin
                Mem_WE = 1'b1;
                if (mem_done) next_state = S_FETCH_MAR;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) next_state = S_PAUSE2;
            end
            S_PAUSE2: begin
                if (!Continue) next_state = S_FETCH_MAR;
            end
            default: next_state = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_ctrl_fsm.sv
// tb/tb_slc3_ctrl_fsm.sv - randomized instruction-level bench for slc3_ctrl_fsm at MEM_WAIT 3, 1 and 5
module tb_slc3_ctrl_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mem_oe, mem_we, busy;
    } ctl_t;

    localparam int NI = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       run_i  [NI];
    logic       cont_i [NI];
    logic [3:0] opc_i  [NI];
    logic       ir5_i  [NI];
    logic       ir11_i [NI];
    logic       ben_i  [NI];
    ctl_t       dut_o  [NI];

    int n_checks = 0;
    int n_pass   = 0;

    ctl_t exp_q[$];
    ctl_t obs_q[$];
    logic cont_q[$];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int MW = (g == 0) ? 3 : (g == 1) ? 1 : 5;
        ctl_t o;
        slc3_ctrl_fsm #(.MEM_WAIT(MW)) dut (
            .Clk        (Clk),
            .Reset      (Reset),
            .Run        (run_i[g]),
            .Continue   (cont_i[g]),
            .Opcode     (opc_i[g]),
            .IR_5       (ir5_i[g]),
            .IR_11      (ir11_i[g]),
            .BEN        (ben_i[g]),
            .LD_MAR     (o.ld_mar),
            .LD_MDR     (o.ld_mdr),
            .LD_IR      (o.ld_ir),
            .LD_BEN     (o.ld_ben),
            .LD_CC      (o.ld_cc),
            .LD_REG     (o.ld_reg),
            .LD_PC      (o.ld_pc),
            .LD_LED     (o.ld_led),
            .GatePC     (o.gate_pc),
            .GateMDR    (o.gate_mdr),
            .GateALU    (o.gate_alu),
            .GateMARMUX (o.gate_marmux),
            .PCMUX      (o.pcmux),
            .DRMUX      (o.drmux),
            .SR1MUX     (o.sr1mux),
            .SR2MUX     (o.sr2mux),
            .ADDR1MUX   (o.addr1mux),
            .ADDR2MUX   (o.addr2mux),
            .ALUK       (o.aluk),
            .Mem_OE     (o.mem_oe),
            .Mem_WE     (o.mem_we),
            .Busy       (o.busy)
        );
        assign dut_o[g] = o;
    end

    function automatic int mw_of(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : 5;
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.drmux = 1'b1;
        return c;
    endfunction

    function automatic ctl_t act();
        ctl_t c = idle();
        c.busy = 1'b1;
        return c;
    endfunction

    // Expected per-cycle control word for one whole instruction, starting at its fetch
    task automatic build_model(input int mw, input logic [3:0] op, input logic ir5, input logic ir11,
                               input logic ben, input int a, input int b);
        ctl_t c;
        int   p0;
        exp_q.delete();
        cont_q.delete();
        c = act(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; exp_q.push_back(c);
        for (int w = 0; w < mw; w++) begin
            c = act(); c.mem_oe = 1; c.ld_mdr = (w == mw - 1); exp_q.push_back(c);
        end
        c = act(); c.gate_mdr = 1; c.ld_ir = 1; exp_q.push_back(c);
        c = act(); c.ld_ben = 1; exp_q.push_back(c);
        p0 = exp_q.size();
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c = act(); c.sr1mux = 1; c.sr2mux = ir5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
                c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
                exp_q.push_back(c);
            end
            4'b0000: begin
                exp_q.push_back(act());
                if (ben) begin
                    c = act(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; exp_q.push_back(c);
                end
            end
            4'b1100: begin
                c = act(); c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; exp_q.push_back(c);
            end
            4'b0100: begin
                c = act(); c.gate_pc = 1; c.drmux = 0; c.ld_reg = 1; exp_q.push_back(c);
                c = act(); c.pcmux = 2'b10; c.ld_pc = 1;
                if (ir11) c.addr2mux = 2'b11;
                else begin c.addr1mux = 1; c.sr1mux = 1; end
                exp_q.push_back(c);
            end
            4'b1110: begin
                c = act(); c.addr2mux = 2'b10; c.gate_marmux = 1; c.ld_reg = 1; c.ld_cc = 1; exp_q.push_back(c);
            end
            4'b0110, 4'b0010, 4'b0111, 4'b0011: begin
                c = act(); c.gate_marmux = 1; c.ld_mar = 1;
                if (op[2]) begin c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; end
                else c.addr2mux = 2'b10;
                exp_q.push_back(c);
                if (!op[0]) begin
                    for (int w = 0; w < mw; w++) begin
                        c = act(); c.mem_oe = 1; c.ld_mdr = (w == mw - 1); exp_q.push_back(c);
                    end
                    c = act(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; exp_q.push_back(c);
                end else begin
                    c = act(); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; exp_q.push_back(c);
                    for (int w = 0; w < mw; w++) begin
                        c = act(); c.mem_we = 1; exp_q.push_back(c);
                    end
                end
            end
            4'b1101: begin
                for (int j = 0; j <= a; j++) begin
                    c = act(); c.ld_led = 1; exp_q.push_back(c);
                end
                for (int j = 0; j < b; j++) exp_q.push_back(act());
            end
            default: ;
        endcase
        // Continue: a zeros, b ones, then zero from the first pause cycle; random where it is ignored
        for (int i = 0; i < exp_q.size(); i++) begin
            if (op == 4'b1101 && i >= p0) cont_q.push_back((i - p0 >= a) && (i - p0 < a + b));
            else cont_q.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            run_i[k] = 0; cont_i[k] = 0; opc_i[k] = 0; ir5_i[k] = 0; ir11_i[k] = 0; ben_i[k] = 0;
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic start(input int k);
        run_i[k] = 1'b1;
        @(posedge Clk); #1;
        run_i[k] = 1'b0;
    endtask

    // Drives n cycles of the planned instruction and records the DUT control word each cycle
    task automatic exec(input int k, input int n);
        obs_q.delete();
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            cont_i[k] = cont_q[i];
            run_i[k]  = 1'($urandom_range(0, 1));
            @(negedge Clk);
            obs_q.push_back(dut_o[k]);
            @(posedge Clk); #1;
        end
        run_i[k] = 1'b0;
    endtask

    task automatic run_instr(input int k, input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int a, input int b);
        opc_i[k] = op; ir5_i[k] = ir5; ir11_i[k] = ir11; ben_i[k] = ben;
        build_model(mw_of(k), op, ir5, ir11, ben, a, b);
        exec(k, exp_q.size());
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1 Reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            run_i[k] = 0; cont_i[k] = 0; opc_i[k] = 0; ir5_i[k] = 0; ir11_i[k] = 0; ben_i[k] = 0;
        end
        run_i[0] = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (dut_o[k] !== idle()) $display("FAIL reset_state[%0d]: got %h want %h", k, dut_o[k], idle());
            else n_pass++;
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (dut_o[0] !== idle()) $display("FAIL halted_before_edge: got %h want %h", dut_o[0], idle());
        else n_pass++;
        @(posedge Clk); #1;
        run_i[0] = 1'b0;
        @(negedge Clk);
        build_model(3, 4'b1111, 0, 0, 0, 0, 1);
        n_checks++;
        if (dut_o[0] !== exp_q[0]) $display("FAIL run_held_fetch: got %h want %h", dut_o[0], exp_q[0]);
        else n_pass++;
        n_checks++;
        if (dut_o[1] !== idle()) $display("FAIL no_run_stays_halted: got %h want %h", dut_o[1], idle());
        else n_pass++;
    endtask

    task automatic test_alu();
        int oe_cycles;
        do_reset();
        start(0);
        run_instr(0, 4'b0001, 1, 0, 0, 0, 1);
        oe_cycles = 0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL add_trace cyc %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            else n_pass++;
            oe_cycles += obs_q[i].mem_oe;
        end
        n_checks++;
        if (oe_cycles != 3) $display("FAIL add_fetch_oe_cycles: got %0d want 3", oe_cycles);
        else n_pass++;
        run_instr(0, 4'b0101, 0, 0, 0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL and_trace cyc %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        start(0);
        for (int t = 0; t < 2; t++) begin
            run_instr(0, 4'b0000, 0, 0, 1'(t), 0, 1);
            n_checks++;
            if (exp_q.size() != 7 + t) $display("FAIL br_model_len: got %0d want %0d", exp_q.size(), 7 + t);
            else n_pass++;
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL br_ben%0d_trace cyc %0d: got %h want %h", t, i + 1, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mem_wait();
        int we_cycles;
        for (int k = 1; k < NI; k++) begin
            do_reset();
            start(k);
            for (int t = 0; t < 3; t++) begin
                run_instr(k, (t == 0) ? 4'b0111 : (t == 1) ? 4'b0011 : 4'b0110, 0, 0, 0, 0, 1);
                we_cycles = 0;
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (obs_q[i] !== exp_q[i]) $display("FAIL mem_mw%0d_op%0d_trace cyc %0d: got %h want %h", mw_of(k), t, i + 1, obs_q[i], exp_q[i]);
                    else n_pass++;
                    n_checks++;
                    if (obs_q[i].mem_oe && obs_q[i].mem_we) $display("FAIL oe_we_overlap mw%0d cyc %0d: got both 1 want exclusive", mw_of(k), i + 1);
                    else n_pass++;
                    we_cycles += obs_q[i].mem_we;
                end
                n_checks++;
                if (we_cycles != ((t < 2) ? mw_of(k) : 0)) $display("FAIL we_cycles mw%0d op%0d: got %0d want %0d", mw_of(k), t, we_cycles, (t < 2) ? mw_of(k) : 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jsr();
        do_reset();
        start(0);
        for (int t = 1; t >= 0; t--) begin
            run_instr(0, 4'b0100, 0, 1'(t), 0, 0, 1);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL jsr_ir11_%0d_trace cyc %0d: got %h want %h", t, i + 1, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_pause();
        int led_cycles;
        do_reset();
        start(0);
        run_instr(0, 4'b1101, 0, 0, 0, 3, 2);
        led_cycles = 0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL pause_trace cyc %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            else n_pass++;
            led_cycles += obs_q[i].ld_led;
        end
        n_checks++;
        if (led_cycles != 4) $display("FAIL pause_led_cycles: got %0d want 4", led_cycles);
        else n_pass++;
        run_instr(0, 4'b1110, 0, 0, 0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL after_pause_lea_trace cyc %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        start(0);
        opc_i[0] = 4'b0111;
        build_model(3, 4'b0111, 0, 0, 0, 0, 1);
        exec(0, 9);
        @(negedge Clk);
        n_checks++;
        if (dut_o[0].mem_we !== 1'b1) $display("FAIL wr_mem_active: got %b want 1", dut_o[0].mem_we);
        else n_pass++;
        #1 Reset = 1'b1;
        #1;
        n_checks++;
        if (dut_o[0] !== idle()) $display("FAIL async_reset_outputs: got %h want %h", dut_o[0], idle());
        else n_pass++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        start(0);
        run_instr(0, 4'b0001, 0, 0, 0, 0, 1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL restart_trace cyc %0d: got %h want %h", i + 1, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int k = 0; k < NI; k++) begin
            do_reset();
            start(k);
            for (int n = 0; n < 25; n++) begin
                op = 4'($urandom_range(0, 15));
                run_instr(k, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
                foreach (exp_q[i]) begin
                    n_checks++;
                    if (obs_q[i] !== exp_q[i]) $display("FAIL rand_mw%0d_n%0d_op%h cyc %0d: got %h want %h", mw_of(k), n, op, i + 1, obs_q[i], exp_q[i]);
                    else n_pass++;
                    n_checks++;
                    if ((obs_q[i].mem_oe && obs_q[i].mem_we) ||
                        ($countones({obs_q[i].gate_pc, obs_q[i].gate_mdr, obs_q[i].gate_alu, obs_q[i].gate_marmux}) > 1))
                        $display("FAIL rand_exclusive mw%0d n%0d cyc %0d: got %h want single gate/strobe", mw_of(k), n, i + 1, obs_q[i]);
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_wait();
        test_jsr();
        test_pause();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
